// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: opcodes, state encodings and datapath select codes shared by control, datapath and ALU control.
package multicycle_control_fsm_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
  function automatic state_t decode_next(input logic [5:0] op);
    return (op == OP_LW || op == OP_SW) ? S_MEMADR :
           (op == OP_RTYPE) ? S_EXEC :
           (op == OP_BEQ)   ? S_BRANCH :
           (op == OP_J)     ? S_JUMP : S_TRAP;
  endfunction
endpackage

// File: rtl/multicycle_control_fsm_decode.sv
// multicycle_control_fsm_decode: pure combinational strobe decode from state; fetch writes wait on mem_ready.
module multicycle_control_fsm_decode
  import multicycle_control_fsm_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: o_ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      default: o_ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequences the shared-memory multicycle MIPS datapath, counts retired instructions,
// and locks into TRAP on an unsupported opcode until reset.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             trap,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic             r_trap;
  logic             w_retire;
  ctrl_t            w_ctrl;
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_next = decode_next(opcode);
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_RWB;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end
  // an instruction retires on its last cycle; a store's last cycle is the one memory accepts it
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_RWB) || (r_state == S_BRANCH) ||
                    (r_state == S_JUMP) || (r_state == S_MEMWR && mem_ready);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_count <= '0;
      r_trap  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + CNT_W'(1);
      if (w_next == S_TRAP) r_trap <= 1'b1;
    end
  end
  multicycle_control_fsm_decode u_decode (
    .i_state    (r_state),
    .i_mem_ready(mem_ready),
    .o_ctrl     (w_ctrl)
  );
  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign IorD        = w_ctrl.i_or_d;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign MemToReg    = w_ctrl.mem_to_reg;
  assign RegDst      = w_ctrl.reg_dst;
  assign RegWrite    = w_ctrl.reg_write;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign ALUOp       = w_ctrl.alu_op;
  assign PCSource    = w_ctrl.pc_source;
  assign trap        = r_trap;
  assign state       = r_state;
  assign instr_count = r_count;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: table-driven instruction sequences plus reset-mid-instruction and trap corner cases.
module tb_multicycle_control_fsm;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic        trap;
  logic [3:0]  state;
  logic [31:0] instr_count;
  logic [15:0] ctrl;
  int          n_checks = 0;
  int          n_fail = 0;
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  localparam logic [15:0] C_FETCH  = 16'h9410;
  localparam logic [15:0] C_FSTALL = 16'h1010;
  localparam logic [15:0] C_DECODE = 16'h0030;
  localparam logic [15:0] C_MEMADR = 16'h0060;
  localparam logic [15:0] C_MEMRD  = 16'h3000;
  localparam logic [15:0] C_MEMWB  = 16'h0280;
  localparam logic [15:0] C_MEMWR  = 16'h2800;
  localparam logic [15:0] C_EXEC   = 16'h0048;
  localparam logic [15:0] C_RWB    = 16'h0180;
  localparam logic [15:0] C_BRANCH = 16'h4045;
  localparam logic [15:0] C_JUMP   = 16'h8002;
  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [31:0] cnt;
  } vec_t;
  vec_t vecs[$];
  multicycle_control_fsm dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .trap(trap), .state(state), .instr_count(instr_count)
  );
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
                 RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                     input logic [15:0] ctl, input logic [31:0] cnt);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cnt = cnt;
    vecs.push_back(v);
  endtask
  task automatic drive(input logic [5:0] op, input logic rdy);
    @(negedge clock);
    opcode = op;
    mem_ready = rdy;
    #1;
  endtask
  initial begin
    // R-type, zero wait
    add(6'h00, 1, 0, C_FETCH, 0);  add(6'h00, 1, 1, C_DECODE, 0);
    add(6'h00, 1, 6, C_EXEC, 0);   add(6'h00, 1, 7, C_RWB, 0);
    // sw with one stall in MEMWR
    add(6'h2B, 1, 0, C_FETCH, 1);  add(6'h2B, 1, 1, C_DECODE, 1);
    add(6'h2B, 1, 2, C_MEMADR, 1); add(6'h2B, 0, 5, C_MEMWR, 1);
    add(6'h2B, 1, 5, C_MEMWR, 1);
    // beq then j
    add(6'h04, 1, 0, C_FETCH, 2);  add(6'h04, 1, 1, C_DECODE, 2);
    add(6'h04, 1, 8, C_BRANCH, 2);
    add(6'h02, 1, 0, C_FETCH, 3);  add(6'h02, 1, 1, C_DECODE, 3);
    add(6'h02, 1, 9, C_JUMP, 3);
    // lw with a fetch stall and two MEMRD stalls
    add(6'h23, 0, 0, C_FSTALL, 4); add(6'h23, 1, 0, C_FETCH, 4);
    add(6'h23, 1, 1, C_DECODE, 4); add(6'h23, 1, 2, C_MEMADR, 4);
    add(6'h23, 0, 3, C_MEMRD, 4);  add(6'h23, 0, 3, C_MEMRD, 4);
    add(6'h23, 1, 3, C_MEMRD, 4);  add(6'h23, 1, 4, C_MEMWB, 4);
    add(6'h23, 0, 0, C_FSTALL, 5);
    #12;
    chk("reset_state", 32'(state), 0);
    chk("reset_count", instr_count, 0);
    chk("reset_trap", 32'(trap), 0);
    chk("reset_ctrl", 32'(ctrl), 32'(C_FSTALL));
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].rdy);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_count", i), instr_count, vecs[i].cnt);
      chk($sformatf("vec%0d_excl", i), 32'((MemRead & MemWrite) | (RegWrite & MemWrite)), 0);
    end
    // async reset in the middle of a stalled MEMRD
    drive(6'h23, 1); drive(6'h23, 1); drive(6'h23, 1); drive(6'h23, 0);
    chk("midrd_state", 32'(state), 3);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_state", 32'(state), 0);
    chk("rst_async_count", instr_count, 0);
    chk("rst_async_memread", 32'(MemRead), 1);
    chk("rst_async_iord", 32'(IorD), 0);
    @(negedge clock);
    reset = 1'b0;
    // one jump to make the count non-zero, then an illegal opcode
    drive(6'h02, 1); drive(6'h02, 1); drive(6'h02, 1);
    drive(6'h3F, 1);
    chk("pretrap_count", instr_count, 1);
    drive(6'h3F, 1);
    chk("decode_before_trap", 32'(state), 1);
    for (int i = 0; i < 20; i++) begin
      drive(i[0] ? 6'h00 : 6'h23, i[1]);
      chk($sformatf("trap%0d_state", i), 32'(state), 10);
      chk($sformatf("trap%0d_flag", i), 32'(trap), 1);
      chk($sformatf("trap%0d_count", i), instr_count, 1);
      chk($sformatf("trap%0d_ctrl", i), 32'(ctrl), 0);
    end
    #2 reset = 1'b1;
    #1;
    chk("trap_clr_flag", 32'(trap), 0);
    chk("trap_clr_state", 32'(state), 0);
    chk("trap_clr_count", instr_count, 0);
    @(negedge clock);
    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
